// File: rtl/camera_pkg.sv
// Shared definitions for the camera frame sequencer: state encoding, readout
// step constants, exposure bounds and the registered-output decode.
package camera_pkg;

  localparam int CAM_EXP_W          = 5;
  localparam int CAM_EXP_MIN        = 2;
  localparam int CAM_EXP_MAX        = 30;
  localparam int CAM_EXP_DEFAULT    = 15;
  localparam int CAM_TICKS_PER_UNIT = 4;

  localparam int RD_STEPS   = 8;
  localparam int RD_STEP_W  = $clog2(RD_STEPS);
  localparam logic [RD_STEP_W-1:0] ADC_STEP_1 = RD_STEP_W'(1);
  localparam logic [RD_STEP_W-1:0] ADC_STEP_2 = RD_STEP_W'(5);
  localparam logic [RD_STEP_W-1:0] RD_GAP_1   = RD_STEP_W'(3);
  localparam logic [RD_STEP_W-1:0] RD_LAST    = RD_STEP_W'(RD_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXPOSE  = 2'd1,
    ST_READOUT = 2'd2
  } state_t;

  typedef struct packed {
    logic erase;
    logic expose;
    logic adc;
    logic nre_1;
    logic nre_2;
    logic busy;
  } out_t;

  localparam out_t OUT_IDLE = '{erase: 1'b1, expose: 1'b0, adc: 1'b0,
                                nre_1: 1'b1, nre_2: 1'b1, busy: 1'b0};

  // Row 1 owns steps 0..2, row 2 owns steps 4..6; steps 3 and 7 are gaps so
  // the two read enables can never overlap.
  function automatic out_t decode_outputs(state_t st, logic [RD_STEP_W-1:0] step);
    out_t o;
    o = OUT_IDLE;
    case (st)
      ST_EXPOSE: begin
        o.erase  = 1'b0;
        o.expose = 1'b1;
        o.busy   = 1'b1;
      end
      ST_READOUT: begin
        o.erase = 1'b0;
        o.busy  = 1'b1;
        if (step < RD_GAP_1)                         o.nre_1 = 1'b0;
        else if ((step > RD_GAP_1) && (step < RD_LAST)) o.nre_2 = 1'b0;
        o.adc = (step == ADC_STEP_1) || (step == ADC_STEP_2);
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/camera_sequencer_if.sv
// User-control and pixel-array/ADC signal bundle of the camera sequencer.
interface camera_sequencer_if #(
  parameter int EXP_W = 5
);
  logic             Init;
  logic             Exp_increase;
  logic             Exp_decrease;
  logic             Erase;
  logic             Expose;
  logic             ADC;
  logic             NRE_1;
  logic             NRE_2;
  logic             Busy;
  logic [EXP_W-1:0] Exp_time;

  modport master (
    output Init, Exp_increase, Exp_decrease,
    input  Erase, Expose, ADC, NRE_1, NRE_2, Busy, Exp_time
  );

  modport slave (
    input  Init, Exp_increase, Exp_decrease,
    output Erase, Expose, ADC, NRE_1, NRE_2, Busy, Exp_time
  );
endinterface

// File: rtl/camera_sequencer_exp_time_reg.sv
// Saturating up/down exposure-time register; only moves while enabled and
// exactly one of inc/dec is requested.
module exp_time_reg #(
  parameter int W       = 5,
  parameter int MIN     = 2,
  parameter int MAX     = 30,
  parameter int DEFAULT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_value
);
  localparam logic [W-1:0] L_MIN     = W'(MIN);
  localparam logic [W-1:0] L_MAX     = W'(MAX);
  localparam logic [W-1:0] L_DEFAULT = W'(DEFAULT);

  logic [W-1:0] r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= L_DEFAULT;
    end else if (i_en && i_inc && !i_dec) begin
      if (r_value < L_MAX) r_value <= r_value + 1'b1;
    end else if (i_en && i_dec && !i_inc) begin
      if (r_value > L_MIN) r_value <= r_value - 1'b1;
    end
  end

  assign o_value = r_value;
endmodule

// File: rtl/camera_sequencer.sv
// Frame sequencer: erase release, timed exposure, then a fixed 8-step
// two-row readout with NRE_1/NRE_2/ADC strobes. Outputs are registered.
module camera_sequencer
  import camera_pkg::*;
#(
  parameter int EXP_W          = CAM_EXP_W,
  parameter int EXP_MIN        = CAM_EXP_MIN,
  parameter int EXP_MAX        = CAM_EXP_MAX,
  parameter int EXP_DEFAULT    = CAM_EXP_DEFAULT,
  parameter int TICKS_PER_UNIT = CAM_TICKS_PER_UNIT
) (
  input  logic                clk,
  input  logic                Reset,
  camera_sequencer_if.slave   bus
);
  localparam int CNT_W = $clog2(EXP_MAX * TICKS_PER_UNIT + 1);

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [RD_STEP_W-1:0]   r_step, w_step_nxt;
  out_t                   r_out, w_out_nxt;
  logic [EXP_W-1:0]       w_exp_time;
  logic                   w_idle;
  logic [CNT_W-1:0]       w_cnt_load;

  assign w_idle = (r_state == ST_IDLE);

  exp_time_reg #(
    .W       (EXP_W),
    .MIN     (EXP_MIN),
    .MAX     (EXP_MAX),
    .DEFAULT (EXP_DEFAULT)
  ) u_exp_time (
    .clk     (clk),
    .rst_n   (Reset),
    .i_en    (w_idle),
    .i_inc   (bus.Exp_increase),
    .i_dec   (bus.Exp_decrease),
    .o_value (w_exp_time)
  );

  // Loaded with length-1 so the zero count is the last exposure cycle;
  // w_exp_time is the pre-update value when inc/dec coincide with Init.
  assign w_cnt_load = CNT_W'(w_exp_time) * CNT_W'(TICKS_PER_UNIT) - CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = r_step;
    case (r_state)
      ST_IDLE: begin
        if (bus.Init) begin
          w_state_nxt = ST_EXPOSE;
          w_cnt_nxt   = w_cnt_load;
          w_step_nxt  = '0;
        end
      end
      ST_EXPOSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_READOUT;
          w_step_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_READOUT: begin
        if (r_step == RD_LAST) begin
          w_state_nxt = ST_IDLE;
          w_step_nxt  = '0;
        end else begin
          w_step_nxt = r_step + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_step_nxt  = '0;
      end
    endcase
    w_out_nxt = decode_outputs(w_state_nxt, w_step_nxt);
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_step  <= '0;
      r_out   <= OUT_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign bus.Erase    = r_out.erase;
  assign bus.Expose   = r_out.expose;
  assign bus.ADC      = r_out.adc;
  assign bus.NRE_1    = r_out.nre_1;
  assign bus.NRE_2    = r_out.nre_2;
  assign bus.Busy     = r_out.busy;
  assign bus.Exp_time = w_exp_time;
endmodule

// File: tb/tb_camera_sequencer.sv
// Directed bench for camera_sequencer: expected frame lengths are queued when
// a frame is requested and compared when the DUT finishes producing it.
module tb_camera_sequencer;
  localparam int EXP_W   = 5;
  localparam int EXP_MIN = 2;
  localparam int EXP_MAX = 30;
  localparam int EXP_DEF = 15;
  localparam int TPU     = 4;

  logic clk = 1'b0;
  logic Reset;

  camera_sequencer_if #(.EXP_W(EXP_W)) bus();

  camera_sequencer #(
    .EXP_W          (EXP_W),
    .EXP_MIN        (EXP_MIN),
    .EXP_MAX        (EXP_MAX),
    .EXP_DEFAULT    (EXP_DEF),
    .TICKS_PER_UNIT (TPU)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int expose_len;
    int busy_len;
  } frame_exp_t;

  frame_exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int m_exp = EXP_DEF;
  // {NRE_1, NRE_2, ADC} for readout steps 0..7
  logic [2:0] rd_table [8] = '{3'b010, 3'b011, 3'b010, 3'b110,
                               3'b100, 3'b101, 3'b100, 3'b110};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_step(int v, logic inc, logic dec);
    if (inc && !dec && v < EXP_MAX) return v + 1;
    if (dec && !inc && v > EXP_MIN) return v - 1;
    return v;
  endfunction

  task automatic adjust(input logic inc, input logic dec, input int ncyc);
    bus.Exp_increase = inc;
    bus.Exp_decrease = dec;
    repeat (ncyc) begin
      @(negedge clk);
      m_exp = sat_step(m_exp, inc, dec);
    end
    bus.Exp_increase = 1'b0;
    bus.Exp_decrease = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_erase"},  32'(bus.Erase),  32'd1);
    check({tag, "_busy"},   32'(bus.Busy),   32'd0);
    check({tag, "_expose"}, 32'(bus.Expose), 32'd0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle
  // that follows the frame.
  task automatic do_frame(input logic hold, input logic dec_during, input string tag);
    frame_exp_t e;
    int n_exp  = 0;
    int n_busy = 0;
    sb.push_back('{m_exp * TPU, m_exp * TPU + 8});
    bus.Init = 1'b1;
    @(negedge clk);
    if (!hold) bus.Init = 1'b0;
    if (dec_during) bus.Exp_decrease = 1'b1;
    e = sb.pop_front();
    check({tag, "_erase_released"}, 32'(bus.Erase), 32'd0);
    while (bus.Expose === 1'b1 && n_exp < 200) begin
      n_exp++;
      if (bus.Busy === 1'b1) n_busy++;
      @(negedge clk);
    end
    check({tag, "_expose_len"}, 32'(n_exp), 32'(e.expose_len));
    if (dec_during) check({tag, "_exp_time_frozen"}, 32'(bus.Exp_time), 32'(m_exp));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_rd_step%0d", tag, i), 32'({bus.NRE_1, bus.NRE_2, bus.ADC}),
            32'(rd_table[i]));
      if (bus.Busy === 1'b1) n_busy++;
      if (i == 7) bus.Exp_decrease = 1'b0;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, 32'(n_busy), 32'(e.busy_len));
    check_idle({tag, "_after"});
  endtask

  always @(negedge clk) begin
    if (Reset === 1'b1) begin
      check("nre_exclusive", 32'(!(bus.NRE_1 === 1'b0 && bus.NRE_2 === 1'b0)), 32'd1);
      check("adc_qualified", 32'(!(bus.ADC === 1'b1) || ((bus.NRE_1 ^ bus.NRE_2) === 1'b1)),
            32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset = 1'b0;
    bus.Init = 1'b0;
    bus.Exp_increase = 1'b0;
    bus.Exp_decrease = 1'b0;

    // Reset held with random inputs
    repeat (4) begin
      @(negedge clk);
      bus.Init         = 1'($urandom_range(0, 1));
      bus.Exp_increase = 1'($urandom_range(0, 1));
      bus.Exp_decrease = 1'($urandom_range(0, 1));
    end
    check_idle("reset");
    check("reset_adc",      32'(bus.ADC),      32'd0);
    check("reset_nre1",     32'(bus.NRE_1),    32'd1);
    check("reset_nre2",     32'(bus.NRE_2),    32'd1);
    check("reset_exp_time", 32'(bus.Exp_time), 32'(EXP_DEF));

    bus.Init = 1'b0;
    bus.Exp_increase = 1'b0;
    bus.Exp_decrease = 1'b0;
    @(negedge clk);
    Reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("post_reset");
    check("post_reset_exp_time", 32'(bus.Exp_time), 32'(EXP_DEF));

    // Default frame
    do_frame(1'b0, 1'b0, "frame_default");

    // Exposure adjustment and saturation
    adjust(1'b1, 1'b0, 20);
    check("inc_sat", 32'(bus.Exp_time), 32'(m_exp));
    check("inc_sat_abs", 32'(bus.Exp_time), 32'(EXP_MAX));
    adjust(1'b0, 1'b1, 40);
    check("dec_sat", 32'(bus.Exp_time), 32'(EXP_MIN));
    adjust(1'b1, 1'b1, 5);
    check("both_held", 32'(bus.Exp_time), 32'(EXP_MIN));
    do_frame(1'b0, 1'b0, "frame_min");

    adjust(1'b1, 1'b0, 13);
    check("back_to_default", 32'(bus.Exp_time), 32'(EXP_DEF));

    // Decrease held during the whole frame is ignored
    do_frame(1'b0, 1'b1, "frame_dec_held");
    check("dec_held_after", 32'(bus.Exp_time), 32'(EXP_DEF));

    // Reset asserted at readout step 1
    bus.Init = 1'b1;
    @(negedge clk);
    bus.Init = 1'b0;
    n = 0;
    while (bus.Expose === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    check("mid_reset_adc_before", 32'(bus.ADC), 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("mid_reset_adc",  32'(bus.ADC),   32'd0);
    check("mid_reset_nre1", 32'(bus.NRE_1), 32'd1);
    check("mid_reset_busy", 32'(bus.Busy),  32'd0);
    check("mid_reset_erase", 32'(bus.Erase), 32'd1);
    m_exp = EXP_DEF;
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    check_idle("mid_reset_idle");
    do_frame(1'b0, 1'b0, "frame_after_reset");

    // Init held: back-to-back frames with one IDLE cycle between
    do_frame(1'b1, 1'b0, "frame_b2b_1");
    do_frame(1'b0, 1'b0, "frame_b2b_2");
    @(negedge clk);
    check_idle("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
